stack_cpu_core: RTL and testbench

- Multicycle 8-bit stack-machine core; the initiator that drives the single-port 32x8 unified instruction/data memory.
- Fetches one instruction per pass and executes it against an internal register stack.
- Issues exactly one memRead or memWrite per memory cycle.
- Consumes the memory's registered read data one cycle after memRead is sampled.

---
 rtl/stack_cpu_core.sv | 124 ++++++++++++
 tb/tb_stack_cpu_core.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/stack_cpu_core.sv
// stack_cpu_core: multicycle 8-bit stack-machine core driving a single-port 32x8 unified memory.
module stack_cpu_core #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 5,
  parameter int STACK_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic [ADDR_W-1:0]              address,
  output logic [DATA_W-1:0]              writeData,
  output logic                           memRead,
  output logic                           memWrite,
  input  logic [DATA_W-1:0]              memData,
  output logic [ADDR_W-1:0]              pc,
  output logic [DATA_W-1:0]              tos,
  output logic [$clog2(STACK_DEPTH):0]   sp,
  output logic                           halted
);
  localparam int IW = $clog2(STACK_DEPTH);
  localparam int SW = IW + 1;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_NOT = 3'd3,
                         OP_PUSH = 3'd4, OP_POP = 3'd5, OP_JMP = 3'd6, OP_JZ = 3'd7;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MRD, MWB, MWR, HALT} state_t;
  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [SW-1:0]       sp_q, sp_d;
  logic                halted_q, halted_d;
  logic [DATA_W-1:0]   stk_q [STACK_DEPTH];
  logic                wr_en;
  logic [IW-1:0]       wr_idx, ti, ni;
  logic [DATA_W-1:0]   wr_val, tos_v, nos_v;
  logic [2:0]          dop, eop;
  logic [ADDR_W-1:0]   da;
  logic                fault;
  assign ti    = sp_q[IW-1:0] - IW'(1);
  assign ni    = ti - IW'(1);
  assign tos_v = (sp_q == '0) ? '0 : stk_q[ti];
  assign nos_v = stk_q[ni];
  assign dop   = memData[DATA_W-1 -: 3];
  assign da    = memData[ADDR_W-1:0];
  assign eop   = ir_q[DATA_W-1 -: 3];
  // Every stack fault is caught while decoding, so no strobe ever follows a faulting opcode.
  assign fault = (dop < OP_NOT && sp_q < SW'(2)) ||
                 ((dop == OP_NOT || dop == OP_POP) && sp_q == '0) ||
                 (dop == OP_PUSH && sp_q == SW'(STACK_DEPTH));
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    sp_d     = sp_q;
    halted_d = halted_q;
    wr_en    = 1'b0;
    wr_idx   = ti;
    wr_val   = tos_v;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: begin
        ir_d = memData;
        pc_d = pc_q + ADDR_W'(1);
        if (fault) begin
          halted_d = 1'b1;
          state_d  = HALT;
        end else if (dop == OP_JMP) begin
          pc_d    = da;
          state_d = FETCH;
        end else if (dop == OP_JZ) begin
          pc_d    = (sp_q != '0 && tos_v == '0) ? da : pc_q + ADDR_W'(1);
          state_d = FETCH;
        end else begin
          state_d = (dop == OP_PUSH) ? MRD : (dop == OP_POP) ? MWR : EXEC;
        end
      end
      EXEC: begin
        wr_en   = 1'b1;
        wr_idx  = (eop == OP_NOT) ? ti : ni;
        wr_val  = (eop == OP_NOT) ? ~tos_v :
                  (eop == OP_ADD) ? nos_v + tos_v :
                  (eop == OP_SUB) ? nos_v - tos_v : nos_v & tos_v;
        sp_d    = (eop == OP_NOT) ? sp_q : sp_q - SW'(1);
        state_d = FETCH;
      end
      MRD: state_d = MWB;
      MWB: begin
        wr_en   = 1'b1;
        wr_idx  = sp_q[IW-1:0];
        wr_val  = memData;
        sp_d    = sp_q + SW'(1);
        state_d = FETCH;
      end
      MWR: begin
        sp_d    = sp_q - SW'(1);
        state_d = FETCH;
      end
      default: state_d = HALT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FETCH;
      pc_q     <= '0;
      ir_q     <= '0;
      sp_q     <= '0;
      halted_q <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stk_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      sp_q     <= sp_d;
      halted_q <= halted_d;
      if (wr_en) stk_q[wr_idx] <= wr_val;
    end
  end
  assign memRead   = !rst && (state_q == FETCH || state_q == MRD);
  assign memWrite  = !rst && state_q == MWR;
  assign address   = rst ? '0 : (state_q == FETCH) ? pc_q :
                     (state_q == MRD || state_q == MWR) ? ir_q[ADDR_W-1:0] : '0;
  assign writeData = memWrite ? tos_v : '0;
  assign pc        = pc_q;
  assign tos       = tos_v;
  assign sp        = sp_q;
  assign halted    = halted_q;
endmodule

// File: tb/tb_stack_cpu_core.sv
// tb_stack_cpu_core: scoreboard bench for stack_cpu_core with a registered-read 32x8 memory model.
module tb_stack_cpu_core;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] address, pc;
  logic [7:0] writeData, memData, tos;
  logic       memRead, memWrite, halted;
  logic [3:0] sp;
  logic [7:0] mem [32];
  logic [7:0] prog [32];
  int         checks = 0;
  int         errors = 0;
  int         wcount = 0;
  bit         mon_en = 1'b0;
  logic [4:0]  rdq [$];
  logic [12:0] wrq [$];
  always #5 clk = ~clk;
  stack_cpu_core dut (
    .clk(clk), .rst(rst), .address(address), .writeData(writeData),
    .memRead(memRead), .memWrite(memWrite), .memData(memData),
    .pc(pc), .tos(tos), .sp(sp), .halted(halted)
  );
  always @(posedge clk) begin
    if (rst) begin
      mem     <= prog;
      memData <= '0;
    end else begin
      if (memWrite) mem[address] <= writeData;
      if (memRead) memData <= mem[address];
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    #1;
    if (mon_en) begin
      if (memRead) begin
        check("rd_excl", {31'd0, memWrite}, 0);
        check("rd_expected", {31'd0, rdq.size() > 0}, 1);
        if (rdq.size() > 0) check("rd_addr", {27'd0, address}, {27'd0, rdq.pop_front()});
      end
      if (memWrite) begin
        wcount++;
        check("wr_expected", {31'd0, wrq.size() > 0}, 1);
        if (wrq.size() > 0) check("wr_data", {19'd0, address, writeData}, {19'd0, wrq.pop_front()});
      end
    end
  end
  task automatic rd(input logic [4:0] a);
    rdq.push_back(a);
  endtask
  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    wrq.push_back({a, d});
  endtask
  task automatic new_test;
    @(negedge clk);
    mon_en = 1'b0;
    check("rd_left", rdq.size(), 0);
    check("wr_left", wrq.size(), 0);
    rdq.delete();
    wrq.delete();
    wcount = 0;
    rst = 1'b1;
    for (int i = 0; i < 32; i++) prog[i] = 8'h00;
  endtask
  task automatic go;
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    #1;
  endtask
  task automatic step;
    @(negedge clk);
    #1;
  endtask
  task automatic run_halt(input int n);
    for (int i = 0; i < n && !halted; i++) step();
    check("halt_reached", {31'd0, halted}, 1);
  endtask
  initial begin
    int n;
    // Reset during MRD of a PUSH abandons it and restarts the fetch at 0.
    new_test();
    prog[0] = 8'h9D; prog[29] = 8'h08;
    rd(0); rd(29); rd(0);
    go();
    check("t1_rd0", {31'd0, memRead}, 1);
    step(); step();
    #1 rst = 1'b1;
    #1;
    check("rst_rd_forced", {31'd0, memRead}, 0);
    check("rst_wr_forced", {31'd0, memWrite}, 0);
    check("rst_addr_forced", {27'd0, address}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_rd", {31'd0, memRead}, 1);
    check("rst_addr", {27'd0, address}, 0);
    check("rst_pc", {27'd0, pc}, 0);
    check("rst_sp", {28'd0, sp}, 0);
    check("rst_halted", {31'd0, halted}, 0);
    check("rst_tos", {24'd0, tos}, 0);
    // PUSH latency: reads in cycles 0 and 2, result and next fetch in cycle 4.
    new_test();
    prog[0] = 8'h9D; prog[29] = 8'h08;
    rd(0); rd(29); rd(1);
    go();
    for (int c = 0; c < 5; c++) begin
      if (c > 0) step();
      check("push_rd_pattern", {31'd0, memRead}, {31'd0, (c % 2) == 0});
      if (c == 3) check("push_sp_c3", {28'd0, sp}, 0);
    end
    check("push_sp_c4", {28'd0, sp}, 1);
    check("push_tos_c4", {24'd0, tos}, 8'h08);
    check("push_fetch_c4", {27'd0, address}, 1);
    // Full program with JZ not taken at 7, taken at 10, ending in an underflow at 21.
    new_test();
    prog[0] = 8'h9D; prog[1] = 8'h9D; prog[2] = 8'h00; prog[3] = 8'hC7;
    prog[7] = 8'hEC; prog[8] = 8'h9E; prog[9] = 8'h20; prog[10] = 8'hEF;
    prog[15] = 8'h9C; prog[16] = 8'h9B; prog[17] = 8'h40; prog[18] = 8'h60;
    prog[19] = 8'hBF; prog[20] = 8'hBE;
    prog[27] = 8'h66; prog[28] = 8'hAA; prog[29] = 8'h08; prog[30] = 8'h10;
    rd(0); rd(29); rd(1); rd(29); rd(2); rd(3); rd(7); rd(8); rd(30); rd(9);
    rd(10); rd(15); rd(28); rd(16); rd(27); rd(17); rd(18); rd(19); rd(20); rd(21);
    wr(31, 8'hDD); wr(30, 8'h00);
    go();
    run_halt(200);
    check("prog_sp", {28'd0, sp}, 0);
    check("prog_pc", {27'd0, pc}, 22);
    check("prog_mem31", {24'd0, mem[31]}, 8'hDD);
    check("prog_mem30", {24'd0, mem[30]}, 8'h00);
    check("prog_wcount", wcount, 2);
    // SUB operand order and 8-bit wrap of SUB and ADD.
    new_test();
    prog[0] = 8'h94; prog[1] = 8'h95; prog[2] = 8'h20; prog[3] = 8'hB8;
    prog[4] = 8'h96; prog[5] = 8'h97; prog[6] = 8'h00; prog[7] = 8'hB9;
    prog[20] = 8'h03; prog[21] = 8'h05; prog[22] = 8'hFF; prog[23] = 8'h02;
    rd(0); rd(20); rd(1); rd(21); rd(2); rd(3); rd(4); rd(22); rd(5); rd(23); rd(6); rd(7); rd(8);
    wr(24, 8'hFE); wr(25, 8'h01);
    go();
    run_halt(100);
    check("alu_pc", {27'd0, pc}, 9);
    check("alu_sub_mem", {24'd0, mem[24]}, 8'hFE);
    check("alu_add_mem", {24'd0, mem[25]}, 8'h01);
    // Nine PUSHes overflow an eight-entry stack in the ninth DECODE.
    new_test();
    for (int i = 0; i < 9; i++) prog[i] = 8'h9D;
    prog[29] = 8'h5A;
    for (int i = 0; i < 8; i++) begin rd(5'(i)); rd(29); end
    rd(8);
    go();
    run_halt(100);
    check("ovf_sp", {28'd0, sp}, 8);
    check("ovf_tos", {24'd0, tos}, 8'h5A);
    check("ovf_pc", {27'd0, pc}, 9);
    n = 0;
    repeat (5) begin step(); n += int'(memRead | memWrite); end
    check("ovf_quiet", n, 0);
    check("ovf_sticky", {31'd0, halted}, 1);
    // POP on an empty stack faults without a write.
    new_test();
    prog[0] = 8'hBF;
    rd(0);
    go();
    run_halt(20);
    check("pop_empty_wcount", wcount, 0);
    check("pop_empty_sp", {28'd0, sp}, 0);
    check("pop_empty_pc", {27'd0, pc}, 1);
    // JMP 31 then NOT at 31: pc wraps and the next fetch is address 0.
    new_test();
    prog[0] = 8'h9D; prog[1] = 8'hDF; prog[29] = 8'h0F; prog[31] = 8'h60;
    rd(0); rd(29); rd(1); rd(31); rd(0);
    go();
    repeat (9) step();
    check("wrap_rd", {31'd0, memRead}, 1);
    check("wrap_addr", {27'd0, address}, 0);
    check("wrap_pc", {27'd0, pc}, 0);
    check("wrap_tos", {24'd0, tos}, 8'hF0);
    check("wrap_sp", {28'd0, sp}, 1);
    check("wrap_halted", {31'd0, halted}, 0);
    new_test();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
